// File: rtl/cpu_types.sv
// Shared types for the program-memory harness: harness FSM states and the
// RISC-V NOP returned for any fetch that does not hit a loaded word.
package cpu_types;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOADED,
    RUN,
    HALT,
    TOUT
  } harness_state_t;

endpackage

// File: rtl/prog_mem_array.sv
// DEPTH x 32 instruction store with per-word valid bits: synchronous write,
// asynchronous read. Valid bits reset; storage contents do not.
module prog_mem_array #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  output logic          rvalid
);

  logic [31:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] valid_d, valid_q;

  // A clear and a write in the same cycle leave only the written word valid.
  always_comb begin
    valid_d = clr ? '0 : valid_q;
    if (we) valid_d[waddr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata  = mem_q[raddr];
  assign rvalid = valid_q[raddr];

endmodule

// File: rtl/prog_mem_harness.sv
// Loads a program into a private instruction memory, holds the CPU in reset
// until started, and supervises the run (ebreak halt, timeout, out-of-range
// fetches). Optional fetch statistics: define PROG_MEM_HARNESS_FETCH_STATS_EN.
module prog_mem_harness
  import cpu_types::*;
#(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  input  logic                     load_last,
  input  logic                     start,
  input  logic [31:0]              pc,
  output logic [31:0]              instruction,
  output logic                     cpu_rst_n,
  input  logic                     ebreak,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic                     pc_oob,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         fetch_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  harness_state_t   state_d, state_q;
  logic             cpu_rst_n_d, cpu_rst_n_q;
  logic             pc_oob_d, pc_oob_q;
  logic [CNT_W-1:0] cycle_count_d, cycle_count_q;
  logic             accept, mem_clr, run_entry, run_stay, pc_in_range;
  logic [31:0]      mem_rdata;
  logic             mem_rvalid;

  assign load_ready  = (state_q != RUN);
  assign accept      = load_valid && load_ready;
  assign pc_in_range = ((pc >> (AW + 2)) == 32'd0);

  prog_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (mem_clr),
    .we     (accept),
    .waddr  (load_addr),
    .wdata  (load_data),
    .raddr  (pc[AW+1:2]),
    .rdata  (mem_rdata),
    .rvalid (mem_rvalid)
  );

  assign instruction = (mem_rvalid && pc_in_range) ? mem_rdata : NOP_INSTR;

  always_comb begin
    state_d = state_q;
    mem_clr = 1'b0;
    case (state_q)
      RUN: begin
        if (ebreak)                            state_d = HALT;
        else if (cycle_count_q == TIMEOUT_LAST) state_d = TOUT;
      end
      LOAD: begin
        if (accept && load_last) state_d = LOADED;
      end
      default: begin
        // IDLE, LOADED, HALT, TOUT: a new beat starts a fresh program.
        if (accept) begin
          mem_clr = 1'b1;
          state_d = load_last ? LOADED : LOAD;
        end else if (state_q == LOADED && start) begin
          state_d = RUN;
        end
      end
    endcase
  end

  assign run_entry = (state_q != RUN) && (state_d == RUN);
  assign run_stay  = (state_q == RUN) && (state_d == RUN);

  // The cycle that leaves RUN is not counted, so counters freeze at that value.
  always_comb begin
    cycle_count_d = cycle_count_q;
    if (run_entry)                      cycle_count_d = '0;
    else if (run_stay && !(&cycle_count_q)) cycle_count_d = cycle_count_q + CNT_W'(1);
  end

  always_comb begin
    pc_oob_d = pc_oob_q;
    if (run_entry)                           pc_oob_d = 1'b0;
    else if (state_q == RUN && !pc_in_range) pc_oob_d = 1'b1;
  end

  assign cpu_rst_n_d = (state_d == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cpu_rst_n_q   <= 1'b0;
      pc_oob_q      <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cpu_rst_n_q   <= cpu_rst_n_d;
      pc_oob_q      <= pc_oob_d;
      cycle_count_q <= cycle_count_d;
    end
  end

`ifdef PROG_MEM_HARNESS_FETCH_STATS_EN
  logic [31:0]      pc_prev_d, pc_prev_q;
  logic [CNT_W-1:0] fetch_count_d, fetch_count_q;

  assign pc_prev_d = pc;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (run_entry) fetch_count_d = '0;
    else if (state_q == RUN && pc != pc_prev_q && !(&fetch_count_q))
      fetch_count_d = fetch_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_prev_q     <= '0;
      fetch_count_q <= '0;
    end else begin
      pc_prev_q     <= pc_prev_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = '0;
`endif

  assign cpu_rst_n   = cpu_rst_n_q;
  assign busy        = (state_q == LOAD) || (state_q == RUN);
  assign done        = (state_q == HALT);
  assign timeout     = (state_q == TOUT);
  assign pc_oob      = pc_oob_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_prog_mem_harness.sv
// Directed bench for prog_mem_harness (DEPTH=16, TIMEOUT_CYCLES=50).
module tb_prog_mem_harness;
  import cpu_types::*;

  localparam int DEPTH = 16;
  localparam int TMO   = 50;
  localparam int CNT_W = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [3:0]  load_addr;
  logic [31:0] load_data;
  logic        load_last;
  logic        start;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        cpu_rst_n;
  logic        ebreak;
  logic        busy, done, timeout, pc_oob;
  logic [CNT_W-1:0] cycle_count, fetch_count;

  int checks = 0;
  int errors = 0;

  prog_mem_harness #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_last   (load_last),
    .start       (start),
    .pc          (pc),
    .instruction (instruction),
    .cpu_rst_n   (cpu_rst_n),
    .ebreak      (ebreak),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .pc_oob      (pc_oob),
    .cycle_count (cycle_count),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beat(input logic [3:0] a, input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [31:0] prog12 [12] = '{
    32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003,
    32'hC0DE_0004, 32'hC0DE_0005, 32'hC0DE_0006, 32'hC0DE_0007,
    32'hC0DE_0008, 32'hC0DE_0009, 32'hC0DE_000A, 32'hC0DE_000B
  };

  initial begin
    #200000;
    $display("FAIL watchdog got=expired exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
    load_last = 1'b0; start = 1'b0; pc = '0; ebreak = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_load_ready", load_ready, 1);
    check("rst_cpu_rst_n", cpu_rst_n, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_pc_oob", pc_oob, 0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_fetch_count", fetch_count, 0);
    check("rst_instr", instruction, NOP);
    rst_n = 1'b1;
    tick();

    // Start in IDLE is ignored
    do_start();
    check("idle_start_busy", busy, 0);
    check("idle_start_cpu_rst", cpu_rst_n, 0);

    // 12-word program, readback, then run to ebreak at word 5
    for (int i = 0; i < 12; i++) begin
      load_beat(4'(i), prog12[i], i == 11);
      if (i == 0) check("load_busy", busy, 1);
    end
    check("loaded_busy", busy, 0);
    check("loaded_cpu_rst", cpu_rst_n, 0);
    for (int i = 0; i < 12; i++) begin
      pc = 32'(4 * i);
      #1;
      check($sformatf("readback_%0d", i), instruction, prog12[i]);
    end
    pc = 32'h30;
    #1;
    check("unloaded_word12", instruction, NOP);
    pc = 32'h0;
    do_start();
    check("run_cpu_rst_n", cpu_rst_n, 1);
    check("run_busy", busy, 1);
    check("run_load_ready", load_ready, 0);
    for (int k = 0; k < 6; k++) begin
      pc = 32'(4 * k);
      ebreak = (k == 5);
      #1;
      check($sformatf("run_fetch_%0d", k), instruction, prog12[k]);
      tick();
    end
    ebreak = 1'b0;
    check("halt_done", done, 1);
    check("halt_cpu_rst_n", cpu_rst_n, 0);
    check("halt_cycle_count", cycle_count, 5);
    check("halt_timeout", timeout, 0);
    check("halt_load_ready", load_ready, 1);
    tick(); tick(); tick();
    check("halt_frozen", cycle_count, 5);

    // 3-word program: out-of-range and unloaded fetches, then timeout
    load_beat(4'd0, 32'h1111_1111, 1'b0);
    check("reload_done_clr", done, 0);
    check("reload_busy", busy, 1);
    load_beat(4'd1, 32'h2222_2222, 1'b0);
    load_beat(4'd2, 32'h3333_3333, 1'b1);
    pc = 32'h14;
    #1;
    check("old_word_cleared", instruction, NOP);
    do_start();
    n = 0;
    pc = 32'h0C;
    #1;
    check("pc_0c_nop", instruction, NOP);
    tick(); n++;
    check("pc_oob_in_range", pc_oob, 0);
    pc = 32'h40;
    #1;
    check("pc_40_nop", instruction, NOP);
    tick(); n++;
    check("pc_oob_set", pc_oob, 1);
    pc = 32'h08;
    #1;
    check("pc_08_word", instruction, 32'h3333_3333);
    while (!timeout && n < 200) begin
      tick(); n++;
    end
    check("tout_cycles", n, TMO);
    check("tout_flag", timeout, 1);
    check("tout_cycle_count", cycle_count, TMO - 1);
    check("tout_done", done, 0);
    check("tout_cpu_rst_n", cpu_rst_n, 0);
    check("tout_pc_oob_held", pc_oob, 1);

    // Single-beat program; ebreak on the 50th cycle beats timeout
    load_beat(4'd0, 32'h0000_006F, 1'b1);
    check("single_beat_busy", busy, 0);
    check("single_beat_timeout_clr", timeout, 0);
    pc = 32'h0;
    do_start();
    check("rerun_pc_oob_clr", pc_oob, 0);
    repeat (TMO - 1) tick();
    check("pre50_count", cycle_count, TMO - 1);
    check("pre50_timeout", timeout, 0);
    check("pre50_busy", busy, 1);
    ebreak = 1'b1;
    tick();
    ebreak = 1'b0;
    check("race_done", done, 1);
    check("race_timeout", timeout, 0);
    check("race_cycle_count", cycle_count, TMO - 1);

    // Overwrite, run, reset mid-RUN, start without reload
    load_beat(4'd0, 32'hAAAA_AAAA, 1'b0);
    load_beat(4'd0, 32'hBBBB_BBBB, 1'b0);
    load_beat(4'd1, 32'hCCCC_CCCC, 1'b1);
    pc = 32'h0;
    #1;
    check("overwrite_word0", instruction, 32'hBBBB_BBBB);
    pc = 32'h4;
    #1;
    check("overwrite_word1", instruction, 32'hCCCC_CCCC);
    do_start();
    tick(); tick(); tick();
    check("midrun_count", cycle_count, 3);
    rst_n = 1'b0;
    #2;
    check("async_rst_busy", busy, 0);
    check("async_rst_cpu_rst_n", cpu_rst_n, 0);
    check("async_rst_count", cycle_count, 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_start();
    tick();
    check("post_rst_start_busy", busy, 0);
    check("post_rst_start_cpu", cpu_rst_n, 0);
    check("post_rst_load_ready", load_ready, 1);
    for (int i = 0; i < 3; i++) begin
      pc = 32'(4 * i);
      #1;
      check($sformatf("post_rst_nop_%0d", i), instruction, NOP);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
